// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 256 x 24-bit data memory between two requesters.
// Fixed priority (port 0) by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int DW  = 24,
  parameter int AW  = 8,
  parameter int MAW = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m0_req,
  input  logic           m0_we,
  input  logic [AW-1:0]  m0_addr,
  input  logic [DW-1:0]  m0_wdata,
  output logic           m0_gnt,
  output logic           m0_rvalid,
  output logic [DW-1:0]  m0_rdata,
  input  logic           m1_req,
  input  logic           m1_we,
  input  logic [AW-1:0]  m1_addr,
  input  logic [DW-1:0]  m1_wdata,
  output logic           m1_gnt,
  output logic           m1_rvalid,
  output logic [DW-1:0]  m1_rdata,
  output logic [MAW-1:0] mem_addr,
  output logic [DW-1:0]  mem_din,
  output logic           mem_we,
  input  logic [DW-1:0]  mem_dout
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_r;
  logic           owner_r;
  logic           cmd_we_r;
  logic [AW-1:0]  cmd_addr_r;
  logic [DW-1:0]  cmd_wdata_r;
  logic           mem_we_r;
  logic [MAW-1:0] mem_addr_r;
  logic [DW-1:0]  mem_din_r;

  logic           win_s;
  logic           win_we_s;
  logic [AW-1:0]  win_addr_s;
  logic [DW-1:0]  win_wdata_s;
  logic [MAW-1:0] win_maddr_s;

`ifdef MEM_ARB_RR_EN
  logic last_owner_r;

  // Round-robin pick: on conflict the port that was not granted last wins
  always_comb begin
    if (m0_req && m1_req) begin
      win_s = ~last_owner_r;
    end else if (m0_req) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // Remember the most recent grant owner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner_r <= 1'b1;
    end else if ((state_r == IDLE) && (m0_req || m1_req)) begin
      last_owner_r <= win_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Fixed priority pick: port 0 always wins
  always_comb begin
    if (m0_req) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`endif

  // Select the winner's command fields and zero-extend its address
  always_comb begin
    win_maddr_s = {MAW{1'b0}};
    if (win_s) begin
      win_we_s    = m1_we;
      win_addr_s  = m1_addr;
      win_wdata_s = m1_wdata;
    end else begin
      win_we_s    = m0_we;
      win_addr_s  = m0_addr;
      win_wdata_s = m0_wdata;
    end
    win_maddr_s[AW-1:0] = win_addr_s;
  end

  // Arbitration FSM with registered grant, memory drive and read return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= {AW{1'b0}};
      cmd_wdata_r <= {DW{1'b0}};
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {MAW{1'b0}};
      mem_din_r   <= {DW{1'b0}};
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_rdata    <= {DW{1'b0}};
      m1_rdata    <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          if (m0_req || m1_req) begin
            state_r     <= BUSY;
            owner_r     <= win_s;
            cmd_we_r    <= win_we_s;
            cmd_addr_r  <= win_addr_s;
            cmd_wdata_r <= win_wdata_s;
            mem_we_r    <= win_we_s;
            mem_addr_r  <= win_maddr_s;
            mem_din_r   <= win_wdata_s;
            m0_gnt      <= ~win_s;
            m1_gnt      <= win_s;
          end else begin
            state_r <= IDLE;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
          end
        end
        BUSY: begin
          state_r    <= IDLE;
          m0_gnt     <= 1'b0;
          m1_gnt     <= 1'b0;
          mem_we_r   <= 1'b0;
          mem_addr_r <= {MAW{1'b0}};
          mem_din_r  <= {DW{1'b0}};
          // Reads capture memory data at the closing edge; writes commit in memory
          if (!cmd_we_r && owner_r) begin
            m1_rdata  <= mem_dout;
            m1_rvalid <= 1'b1;
          end else if (!cmd_we_r) begin
            m0_rdata  <= mem_dout;
            m0_rvalid <= 1'b1;
          end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          m0_gnt   <= 1'b0;
          m1_gnt   <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_r;
  assign mem_din  = mem_din_r;
  // Reset landing in the BUSY cycle must block the write from committing
  assign mem_we   = mem_we_r & rst_n;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a behavioural memory and a read-return scoreboard.
// Covers reset, write/read, conflicts (fixed or MEM_ARB_RR_EN), reset mid-access, back-to-back.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [23:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [23:0] m0_rdata, m1_rdata;
  logic [23:0] mem_addr;
  logic [23:0] mem_din;
  logic        mem_we;
  logic [23:0] mem_dout;

  typedef struct packed {
    logic        port;
    logic [23:0] data;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [23:0] mem [256];
  logic [23:0] ref_mem [256];
  int          checks = 0;
  int          errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write at rising edge
  assign mem_dout = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic port, input logic [7:0] addr);
    sb_t e;
    e.port = port;
    e.data = ref_mem[addr];
    sb.push_back(e);
  endtask

  // Single uncontested access with full cycle-level checks
  task automatic do_access(input logic port, input logic we, input logic [7:0] addr,
                           input logic [23:0] wd);
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
    if (we) ref_mem[addr] = wd;
    else push_read(port, addr);
    tick();
    chk("gnt_owner", 32'(port ? m1_gnt : m0_gnt), 32'd1);
    chk("gnt_other", 32'(port ? m0_gnt : m1_gnt), 32'd0);
    chk("mem_addr_busy", 32'(mem_addr), {24'h0, addr});
    chk("mem_we_busy", 32'(mem_we), 32'(we));
    chk("mem_din_busy", 32'(mem_din), {8'h0, wd});
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    chk("gnt_drop", {30'h0, m0_gnt, m1_gnt}, 32'd0);
    chk("mem_idle", {7'h0, mem_we, mem_addr}, 32'd0);
    chk("rvalid_latency", 32'(port ? m1_rvalid : m0_rvalid), 32'(!we));
    tick();
    chk("rvalid_pulse", {30'h0, m0_rvalid, m1_rvalid}, 32'd0);
  endtask

  // Read-return monitor: every rvalid pops the oldest expected read
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      chk("rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_rvalid: observed rvalid m0=%0b m1=%0b expected none",
               m0_rvalid, m1_rvalid);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rv_port", 32'(m1_rvalid), 32'(mon_e.port));
        chk("rv_data", 32'(m1_rvalid ? m1_rdata : m0_rdata), {8'h0, mon_e.data});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 24'h0;
      ref_mem[i] = 24'h0;
    end
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20; m0_wdata = 24'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h21; m1_wdata = 24'h0;

    // Reset held two cycles with both requests asserted
    tick();
    tick();
    chk("rst_gnt", {30'h0, m0_gnt, m1_gnt}, 32'd0);
    chk("rst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("rst_rdata", {m0_rdata[15:0], m1_rdata[15:0]} | {24'h0, m0_rdata[23:16] | m1_rdata[23:16]}, 32'd0);
    chk("rst_mem", {7'h0, mem_we, mem_addr}, 32'd0);
    rst_n = 1'b1;
    push_read(1'b0, 8'h20);
    tick();
    chk("rst_first_gnt0", 32'(m0_gnt), 32'd1);
    chk("rst_first_gnt1", 32'(m1_gnt), 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // Port 0 write then read back
    do_access(1'b0, 1'b1, 8'h0D, 24'hABCDEF);
    do_access(1'b0, 1'b0, 8'h0D, 24'h0);
    chk("p0_rdata_hold", 32'(m0_rdata), 32'hABCDEF);

    // Preload, then conflicting reads
    do_access(1'b0, 1'b1, 8'h0E, 24'h000111);
    do_access(1'b1, 1'b1, 8'h0F, 24'h000222);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h0E;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h0F;
    push_read(1'b0, 8'h0E);
    push_read(1'b1, 8'h0F);
    tick();
    chk("conf_first_gnt", {30'h0, m0_gnt, m1_gnt}, 32'd2);
    m0_req = 1'b0;
    tick();
    chk("conf_p0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("conf_m1_untouched", 32'(m1_rdata), 32'd0);
    tick();
    chk("conf_second_gnt", {30'h0, m0_gnt, m1_gnt}, 32'd1);
    m1_req = 1'b0;
    tick();
    chk("conf_p1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("conf_m0_held", 32'(m0_rdata), 32'h000111);
    tick();

    // Both requests held across four accesses
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic p;
`ifdef MEM_ARB_RR_EN
      p = k[0];
`else
      p = 1'b0;
`endif
      push_read(p, p ? 8'h0F : 8'h0E);
      tick();
      chk("held_gnt", {30'h0, m0_gnt, m1_gnt}, p ? 32'd1 : 32'd2);
      tick();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // Reset asserted in the BUSY cycle of a port 1 write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h05; m1_wdata = 24'h123456;
    tick();
    chk("midrst_gnt", 32'(m1_gnt), 32'd1);
    chk("midrst_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_forced", 32'(mem_we), 32'd0);
    m1_req = 1'b0;
    tick();
    chk("midrst_rvalid", {30'h0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("midrst_gnt_clear", {30'h0, m0_gnt, m1_gnt}, 32'd0);
    chk("midrst_rdata0", 32'(m0_rdata), 32'd0);
    chk("midrst_rdata1", 32'(m1_rdata), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", {30'h0, m0_gnt, m1_gnt}, 32'd0);
    do_access(1'b0, 1'b0, 8'h05, 24'h0);

    // Back-to-back: port 1 write, port 0 read waiting during BUSY
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h04; m1_wdata = 24'h00FFFF;
    ref_mem[8'h04] = 24'h00FFFF;
    tick();
    chk("b2b_wgnt", {30'h0, m0_gnt, m1_gnt}, 32'd1);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h04;
    push_read(1'b0, 8'h04);
    tick();
    chk("b2b_pending", {30'h0, m0_gnt, m1_gnt}, 32'd0);
    tick();
    chk("b2b_rgnt", {30'h0, m0_gnt, m1_gnt}, 32'd2);
    chk("b2b_raddr", 32'(mem_addr), 32'h4);
    m0_req = 1'b0;
    tick();
    chk("b2b_rvalid", 32'(m0_rvalid), 32'd1);
    chk("b2b_rdata", 32'(m0_rdata), 32'h00FFFF);
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
